// File: rtl/ped_crossing_ctrl.sv
// Pedestrian-crossing controller: grants a timed WALK then FLASH clearance inside a fresh red
// phase of the upstream traffic light, and latches a sticky fault on unsafe light sequences.
module ped_crossing_ctrl #(
    parameter int WALK_CYCLES  = 8,
    parameter int FLASH_CYCLES = 4,
    parameter int CNT_W        = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       light,
    input  logic             ped_btn,
    output logic             walk,
    output logic             dont_walk,
    output logic             flash,
    output logic [CNT_W-1:0] countdown,
    output logic             req_pending,
    output logic             fault
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RED = 3'd1,
        S_WALK     = 3'd2,
        S_FLASH    = 3'd3,
        S_FAULT    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(WALK_CYCLES + FLASH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_FLASH = CNT_W'(FLASH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [2:0]       prev_light_r;
    logic             walk_r;
    logic             dont_walk_r;
    logic             flash_r;
    logic             req_pending_r;
    logic             fault_r;
    logic             legal_s;
    logic             red_s;
    logic             onset_s;

    assign legal_s = (light == 3'b100) || (light == 3'b010) || (light == 3'b001);
    assign red_s   = (light == 3'b100);
    assign onset_s = red_s && (prev_light_r != 3'b100);

    // Next-state and countdown; the counter is zero outside WALK/FLASH.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = '0;
        case (state_r)
            S_IDLE: begin
                if (!legal_s) begin
                    state_nxt_s = S_FAULT;
                end else if (ped_btn) begin
                    state_nxt_s = S_WAIT_RED;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_WAIT_RED: begin
                if (!legal_s) begin
                    state_nxt_s = S_FAULT;
                end else if (onset_s) begin
                    state_nxt_s = S_WALK;
                    cnt_nxt_s   = CNT_START;
                end else begin
                    state_nxt_s = S_WAIT_RED;
                end
            end
            S_WALK: begin
                // Anything but red (illegal values included) while pedestrians cross is unsafe.
                if (!red_s) begin
                    state_nxt_s = S_FAULT;
                end else if (cnt_r == CNT_FLASH) begin
                    state_nxt_s = S_FLASH;
                    cnt_nxt_s   = cnt_r - CNT_ONE;
                end else begin
                    state_nxt_s = S_WALK;
                    cnt_nxt_s   = cnt_r - CNT_ONE;
                end
            end
            S_FLASH: begin
                if (!red_s) begin
                    state_nxt_s = S_FAULT;
                end else if (cnt_r == '0) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_FLASH;
                    cnt_nxt_s   = cnt_r - CNT_ONE;
                end
            end
            S_FAULT: begin
                state_nxt_s = S_FAULT;
            end
            default: begin
                state_nxt_s = S_FAULT;
            end
        endcase
    end

    // State, light history and registered output decode of the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= S_IDLE;
            cnt_r         <= '0;
            prev_light_r  <= 3'b100;
            walk_r        <= 1'b0;
            dont_walk_r   <= 1'b1;
            flash_r       <= 1'b0;
            req_pending_r <= 1'b0;
            fault_r       <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            cnt_r         <= cnt_nxt_s;
            prev_light_r  <= light;
            walk_r        <= (state_nxt_s == S_WALK);
            dont_walk_r   <= (state_nxt_s != S_WALK);
            flash_r       <= (state_nxt_s == S_FLASH);
            req_pending_r <= (state_nxt_s == S_WAIT_RED);
            fault_r       <= (state_nxt_s == S_FAULT);
        end
    end

    assign walk        = walk_r;
    assign dont_walk   = dont_walk_r;
    assign flash       = flash_r;
    assign countdown   = cnt_r;
    assign req_pending = req_pending_r;
    assign fault       = fault_r;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Bench for ped_crossing_ctrl: directed scenarios plus random light/button traffic, checked
// every cycle against a phase/age model of the crossing.
module tb_ped_crossing_ctrl;
    localparam int W  = 8;
    localparam int F  = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    light;
    logic          ped_btn;
    logic          walk, dont_walk, flash, req_pending, fault;
    logic [CW-1:0] countdown;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // model: mode 0 idle, 1 waiting for red, 2 crossing (age = edges since grant), 3 fault
    int         m_mode;
    int         m_age;
    logic [2:0] m_prev;

    ped_crossing_ctrl #(.WALK_CYCLES(W), .FLASH_CYCLES(F), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .light(light), .ped_btn(ped_btn),
        .walk(walk), .dont_walk(dont_walk), .flash(flash), .countdown(countdown),
        .req_pending(req_pending), .fault(fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mode <= 0;
            m_age  <= 0;
            m_prev <= 3'b100;
        end else begin
            m_prev <= light;
            if (m_mode == 3)
                m_mode <= 3;
            else if (!(light == 3'b100 || light == 3'b010 || light == 3'b001))
                m_mode <= 3;
            else if (m_mode == 2 && light != 3'b100)
                m_mode <= 3;
            else if (m_mode == 0 && ped_btn)
                m_mode <= 1;
            else if (m_mode == 1 && light == 3'b100 && m_prev != 3'b100) begin
                m_mode <= 2;
                m_age  <= 0;
            end else if (m_mode == 2) begin
                if (m_age == W + F - 1) m_mode <= 0;
                else                    m_age  <= m_age + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_walk",      32'(walk),        32'(m_mode == 2 && m_age < W));
            check("model_dont_walk", 32'(dont_walk),   32'(!(m_mode == 2 && m_age < W)));
            check("model_flash",     32'(flash),       32'(m_mode == 2 && m_age >= W));
            check("model_countdown", 32'(countdown),   (m_mode == 2) ? 32'(W + F - 1 - m_age) : 32'd0);
            check("model_req",       32'(req_pending), 32'(m_mode == 1));
            check("model_fault",     32'(fault),       32'(m_mode == 3));
        end
    end

    task automatic cyc(input logic [2:0] l, input logic b);
        light   = l;
        ped_btn = b;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_walk"},      32'(walk),        32'd0);
        check({tag, "_dont_walk"}, 32'(dont_walk),   32'd1);
        check({tag, "_flash"},     32'(flash),       32'd0);
        check({tag, "_countdown"}, 32'(countdown),   32'd0);
        check({tag, "_req"},       32'(req_pending), 32'd0);
        check({tag, "_fault"},     32'(fault),       32'd0);
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        light   = 3'($urandom);
        ped_btn = 1'($urandom);
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        reset = 1'b1;
    endtask

    initial begin
        logic [2:0] bad_l [2];
        bad_l[0] = 3'b110;
        bad_l[1] = 3'b000;
        reset    = 1'b0;
        light    = 3'b001;
        ped_btn  = 1'b0;
        do_reset();
        chk_en = 1'b1;

        // normal crossing
        cyc(3'b001, 1'b1);
        check("nc_req", 32'(req_pending), 32'd1);
        repeat (3) cyc(3'b010, 1'b0);
        cyc(3'b100, 1'b0);
        check("nc_walk_rise", 32'(walk), 32'd1);
        check("nc_dont_walk", 32'(dont_walk), 32'd0);
        check("nc_cd_start", 32'(countdown), 32'd11);
        check("nc_req_clear", 32'(req_pending), 32'd0);
        for (int i = 1; i < 8; i++) begin
            cyc(3'b100, 1'b0);
            check("nc_walk_hold", 32'(walk), 32'd1);
            check("nc_walk_cd", 32'(countdown), 32'(11 - i));
        end
        for (int i = 0; i < 4; i++) begin
            cyc(3'b100, 1'b0);
            check("nc_flash", 32'(flash), 32'd1);
            check("nc_flash_walk", 32'(walk), 32'd0);
            check("nc_flash_cd", 32'(countdown), 32'(3 - i));
        end
        cyc(3'b100, 1'b0);
        check_idle_outputs("nc_end");
        repeat (7) cyc(3'b100, 1'b0);

        // no request
        for (int k = 0; k < 2; k++) begin
            repeat (3) cyc(3'b001, 1'b0);
            repeat (2) cyc(3'b010, 1'b0);
            repeat (14) cyc(3'b100, 1'b0);
        end
        check_idle_outputs("noreq");

        // late press, then unsafe transition mid-walk
        do_reset();
        repeat (5) cyc(3'b100, 1'b0);
        cyc(3'b100, 1'b1);
        check("late_req", 32'(req_pending), 32'd1);
        repeat (6) cyc(3'b100, 1'b0);
        check("late_no_walk", 32'(walk), 32'd0);
        cyc(3'b001, 1'b0);
        cyc(3'b010, 1'b0);
        cyc(3'b100, 1'b0);
        check("late_walk", 32'(walk), 32'd1);
        check("late_cd", 32'(countdown), 32'd11);
        repeat (5) cyc(3'b100, 1'b0);
        check("unsafe_cd6", 32'(countdown), 32'd6);
        cyc(3'b001, 1'b0);
        check("unsafe_fault", 32'(fault), 32'd1);
        check("unsafe_walk", 32'(walk), 32'd0);
        check("unsafe_dont_walk", 32'(dont_walk), 32'd1);
        check("unsafe_cd", 32'(countdown), 32'd0);
        cyc(3'b001, 1'b1);
        cyc(3'b010, 1'b0);
        cyc(3'b100, 1'b1);
        repeat (3) cyc(3'b100, 1'b0);
        check("unsafe_sticky", 32'(fault), 32'd1);
        check("unsafe_no_walk", 32'(walk), 32'd0);

        // asynchronous reset in the middle of WALK
        do_reset();
        cyc(3'b001, 1'b1);
        cyc(3'b010, 1'b0);
        cyc(3'b100, 1'b0);
        cyc(3'b100, 1'b0);
        check("mid_walk_before", 32'(walk), 32'd1);
        reset = 1'b0;
        #2;
        check_idle_outputs("mid_reset");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // illegal light values in IDLE
        for (int b = 0; b < 2; b++) begin
            do_reset();
            cyc(3'b001, 1'b0);
            cyc(bad_l[b], 1'b0);
            check("illegal_fault", 32'(fault), 32'd1);
            cyc(3'b001, 1'b1);
            cyc(3'b010, 1'b0);
            repeat (3) cyc(3'b100, 1'b0);
            check("illegal_sticky", 32'(fault), 32'd1);
            check("illegal_no_walk", 32'(walk), 32'd0);
        end

        // random traffic: legal phases, occasionally short reds and illegal glitches
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int p = 0; p < 8; p++) begin
                int g_len, y_len, r_len;
                g_len = $urandom_range(1, 4);
                y_len = $urandom_range(1, 3);
                r_len = ($urandom_range(0, 9) < 8) ? $urandom_range(12, 20) : $urandom_range(3, 11);
                repeat (g_len) cyc(3'b001, 1'($urandom_range(0, 3) == 0));
                repeat (y_len) cyc(3'b010, 1'($urandom_range(0, 3) == 0));
                for (int c = 0; c < r_len; c++) begin
                    if ($urandom_range(0, 99) < 2) cyc(3'($urandom), 1'($urandom));
                    else                           cyc(3'b100, 1'($urandom_range(0, 3) == 0));
                end
            end
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
